wb_interconnect_rr: RTL and testbench

Parametrised Wishbone shared-bus interconnect that arbitrates `numm` pipelined masters onto `nums` address-mapped slaves. It adds round-robin arbitration, an error response for unmapped addresses, an outstanding-beat limit and a response-timeout watchdog. It sits between the Ibex instruction/data ports (plus optional debug master) and the SoC peripherals, replacing the fixed-priority shared bus in the SoC top.

---
 rtl/wb_ic_pkg.sv | 43 ++++
 rtl/wb_rr_arbiter.sv | 61 ++++++
 rtl/wb_interconnect_rr.sv | 236 +++++++++++++++++++++++
 tb/tb_wb_interconnect_rr.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_ic_pkg.sv
// Shared types and helpers for the round-robin Wishbone interconnect.
//   ic_state_e : ownership FSM states (idle, owned, draining late responses)
//   dec_t      : address decode result (hit flag plus slave index)
//   decode()   : maps an address onto a flattened base/size table
package wb_ic_pkg;

  localparam int unsigned MAX_SLAVES = 16;
  localparam int unsigned OUTST_W    = $clog2(16);
  localparam int unsigned ALLW       = MAX_SLAVES * 32;

  typedef enum logic [1:0] {
    StIdle,
    StOwn,
    StDrain
  } ic_state_e;

  typedef struct packed {
    logic       hit;
    logic [3:0] idx;
  } dec_t;

  // Slave i occupies [base, base+size). Scanning downwards lets the lowest
  // matching index overwrite any higher match.
  function automatic dec_t decode(input logic [31:0]     adr,
                                  input logic [ALLW-1:0] bases,
                                  input logic [ALLW-1:0] sizes,
                                  input int unsigned     n);
    dec_t        res;
    logic [31:0] b;
    logic [31:0] s;
    res = '0;
    for (int i = MAX_SLAVES - 1; i >= 0; i--) begin
      b = bases[i*32 +: 32];
      s = sizes[i*32 +: 32];
      if (i < int'(n) && adr >= b && (adr - b) < s) begin
        res.hit = 1'b1;
        res.idx = 4'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter with a registered grant.
//   i_req     : per-master request (cyc)
//   i_release : owner is done; the bus goes idle next cycle
//   o_grant   : index of the current (or most recent) owner
//   o_valid   : a grant is held
// While no grant is held, the first requester after the previous winner is
// captured. A release always costs one idle cycle before the next capture.
module wb_rr_arbiter #(
  parameter int unsigned numm = 2,
  localparam int unsigned GW  = (numm > 1) ? $clog2(numm) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [numm-1:0] i_req,
  input  logic            i_release,
  output logic [GW-1:0]   o_grant,
  output logic            o_valid
);

  logic [GW-1:0] r_grant;
  logic [GW-1:0] r_last;
  logic          r_valid;
  logic [GW-1:0] w_pick;
  logic          w_found;
  logic [31:0]   w_idx;

  always_comb begin
    w_pick  = r_last;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 1; k <= numm; k++) begin
      w_idx = (32'(r_last) + 32'(k)) % numm;
      for (int m = 0; m < numm; m++) begin
        if (!w_found && i_req[m] && 32'(m) == w_idx) begin
          w_found = 1'b1;
          w_pick  = GW'(m);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_grant <= '0;
      r_last  <= GW'(numm - 1);
    end else if (!r_valid) begin
      if (w_found) begin
        r_valid <= 1'b1;
        r_grant <= w_pick;
        r_last  <= w_pick;
      end
    end else if (i_release) begin
      r_valid <= 1'b0;
    end
  end

  assign o_grant = r_grant;
  assign o_valid = r_valid;

endmodule

// File: rtl/wb_interconnect_rr.sv
// Shared-bus Wishbone interconnect: numm pipelined masters onto nums
// address-mapped slaves with round-robin ownership, unmapped-address error,
// outstanding-beat limit and response watchdog.
//   i_wbm_* / o_wbm_* : master ports, flattened (32-bit fields at m*32, sel at m*4)
//   o_wbs_* / i_wbs_* : slave ports, flattened the same way per slave
//   o_grant           : current owner index, valid while o_busy
//   o_busy            : a master owns the bus
//   o_bus_err         : one-cycle pulse on unmapped access or timeout
module wb_interconnect_rr
  import wb_ic_pkg::*;
#(
  parameter int unsigned        numm      = 2,
  parameter int unsigned        nums      = 5,
  parameter logic [nums*32-1:0] base_addr = {32'h1002_0000, 32'h1001_0000, 32'h1000_1000,
                                             32'h1000_0000, 32'h0000_0000},
  parameter logic [nums*32-1:0] size      = {32'h0000_1000, 32'h0000_1000, 32'h0000_1000,
                                             32'h0000_1000, 32'h0010_0000},
  parameter int unsigned        MAX_OUTST = 4,
  parameter int unsigned        TIMEOUT   = 1024,
  localparam int unsigned       GW        = (numm > 1) ? $clog2(numm) : 1
) (
  input  logic              clk,
  input  logic              rst,
  // master ports
  input  logic [numm-1:0]    i_wbm_cyc,
  input  logic [numm-1:0]    i_wbm_stb,
  input  logic [numm-1:0]    i_wbm_we,
  input  logic [numm*4-1:0]  i_wbm_sel,
  input  logic [numm*32-1:0] i_wbm_adr,
  input  logic [numm*32-1:0] i_wbm_dat,
  output logic [numm*32-1:0] o_wbm_dat,
  output logic [numm-1:0]    o_wbm_ack,
  output logic [numm-1:0]    o_wbm_err,
  output logic [numm-1:0]    o_wbm_stall,
  // slave ports
  output logic [nums-1:0]    o_wbs_cyc,
  output logic [nums-1:0]    o_wbs_stb,
  output logic [nums-1:0]    o_wbs_we,
  output logic [nums*4-1:0]  o_wbs_sel,
  output logic [nums*32-1:0] o_wbs_adr,
  output logic [nums*32-1:0] o_wbs_dat,
  input  logic [nums*32-1:0] i_wbs_dat,
  input  logic [nums-1:0]    i_wbs_ack,
  input  logic [nums-1:0]    i_wbs_err,
  input  logic [nums-1:0]    i_wbs_stall,
  // status
  output logic [GW-1:0]      o_grant,
  output logic               o_busy,
  output logic               o_bus_err
);

  localparam logic [ALLW-1:0] BASES = ALLW'(base_addr);
  localparam logic [ALLW-1:0] SIZES = ALLW'(size);

  ic_state_e          r_state;
  ic_state_e          w_state_d;
  logic [OUTST_W-1:0] r_outst;
  logic [OUTST_W-1:0] w_outst_d;
  logic [3:0]         r_tgt;        // slave of the outstanding beats
  logic               r_unm_pend;   // unmapped beat accepted last cycle
  logic [31:0]        r_wdog;
  logic [31:0]        w_wdog_d;

  logic [GW-1:0] w_grant;
  logic          w_arb_valid;
  logic          w_release;

  logic        w_own_cyc, w_own_stb, w_own_we;
  logic [3:0]  w_own_sel;
  logic [31:0] w_own_adr, w_own_dat;
  dec_t        w_dec;

  logic        w_tgt_ack, w_tgt_err, w_dec_stall;
  logic [31:0] w_tgt_dat;
  logic        w_own, w_pend, w_full;
  logic        w_sack, w_serr, w_rsp, w_timeout;
  logic        w_block, w_own_stall, w_acc, w_slv_stb;

  wb_rr_arbiter #(
    .numm (numm)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_wbm_cyc),
    .i_release (w_release),
    .o_grant   (w_grant),
    .o_valid   (w_arb_valid)
  );

  // Owner's request signals.
  always_comb begin
    w_own_cyc = 1'b0;
    w_own_stb = 1'b0;
    w_own_we  = 1'b0;
    w_own_sel = '0;
    w_own_adr = '0;
    w_own_dat = '0;
    for (int m = 0; m < numm; m++) begin
      if (GW'(m) == w_grant) begin
        w_own_cyc = i_wbm_cyc[m];
        w_own_stb = i_wbm_stb[m];
        w_own_we  = i_wbm_we[m];
        w_own_sel = i_wbm_sel[m*4 +: 4];
        w_own_adr = i_wbm_adr[m*32 +: 32];
        w_own_dat = i_wbm_dat[m*32 +: 32];
      end
    end
  end

  assign w_dec = decode(w_own_adr, BASES, SIZES, nums);

  // Response from the slave holding outstanding beats; stall from the decoded one.
  always_comb begin
    w_tgt_ack   = 1'b0;
    w_tgt_err   = 1'b0;
    w_tgt_dat   = '0;
    w_dec_stall = 1'b1;
    for (int s = 0; s < nums; s++) begin
      if (4'(s) == r_tgt) begin
        w_tgt_ack = i_wbs_ack[s];
        w_tgt_err = i_wbs_err[s];
        w_tgt_dat = i_wbs_dat[s*32 +: 32];
      end
      if (4'(s) == w_dec.idx) begin
        w_dec_stall = i_wbs_stall[s];
      end
    end
  end

  always_comb begin
    w_own  = (r_state == StOwn);
    w_pend = (r_outst != '0);
    w_full = (r_outst == OUTST_W'(MAX_OUTST));
    // Responses only count when a beat is expected, so late ones are dropped.
    w_sack = w_pend && !r_unm_pend && w_tgt_ack;
    w_serr = w_pend && !r_unm_pend && w_tgt_err;
    w_rsp  = w_sack || w_serr || r_unm_pend;
    w_timeout = (TIMEOUT != 0) && w_pend && !w_rsp && (r_wdog == 32'(TIMEOUT - 1));
    // Beats may not cross slaves while any are outstanding; unmapped beats
    // are only taken on an empty pipe.
    w_block = w_full || r_unm_pend || w_timeout ||
              (w_pend && (!w_dec.hit || w_dec.idx != r_tgt));
    w_own_stall = w_block || (w_dec.hit && w_dec_stall);
    w_acc       = w_own && w_own_cyc && w_own_stb && !w_own_stall;
    w_slv_stb   = w_own && w_own_cyc && w_own_stb && w_dec.hit && !w_block;
  end

  always_comb begin
    w_outst_d = r_outst;
    if (w_timeout) begin
      w_outst_d = '0;
    end else begin
      unique case ({w_acc, w_rsp})
        2'b10:   w_outst_d = r_outst + 1'b1;
        2'b01:   w_outst_d = r_outst - 1'b1;
        default: w_outst_d = r_outst;
      endcase
    end
    w_wdog_d = (!w_pend || w_rsp || w_timeout) ? '0 : r_wdog + 32'd1;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (|i_wbm_cyc) w_state_d = StOwn;
      StOwn:   if (!w_own_cyc) w_state_d = (w_outst_d == '0) ? StIdle : StDrain;
      StDrain: if (w_outst_d == '0 || w_timeout) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
    w_release = (r_state != StIdle) && (w_state_d == StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_outst    <= '0;
      r_tgt      <= '0;
      r_unm_pend <= 1'b0;
      r_wdog     <= '0;
    end else begin
      r_state    <= w_state_d;
      r_outst    <= w_outst_d;
      r_unm_pend <= w_acc && !w_dec.hit;
      r_wdog     <= w_wdog_d;
      if (w_acc && w_dec.hit) r_tgt <= w_dec.idx;
    end
  end

  // Slave side: request fields only to the decoded slave; cyc follows the
  // outstanding slave when beats are in flight, and drops for the timeout cycle.
  always_comb begin
    o_wbs_cyc = '0;
    o_wbs_stb = '0;
    o_wbs_we  = '0;
    o_wbs_sel = '0;
    o_wbs_adr = '0;
    o_wbs_dat = '0;
    for (int s = 0; s < nums; s++) begin
      if (!w_timeout && r_state != StIdle) begin
        if (w_pend) begin
          o_wbs_cyc[s] = (r_tgt == 4'(s)) && !r_unm_pend;
        end else begin
          o_wbs_cyc[s] = w_own && w_own_cyc && w_dec.hit && (w_dec.idx == 4'(s));
        end
      end
      if (w_own && w_dec.hit && w_dec.idx == 4'(s)) begin
        o_wbs_stb[s]          = w_slv_stb;
        o_wbs_we[s]           = w_own_we;
        o_wbs_sel[s*4 +: 4]   = w_own_sel;
        o_wbs_adr[s*32 +: 32] = w_own_adr;
        o_wbs_dat[s*32 +: 32] = w_own_dat;
      end
    end
  end

  // Master side: only the owner in OWN sees responses; everyone else is stalled.
  always_comb begin
    o_wbm_dat   = '0;
    o_wbm_ack   = '0;
    o_wbm_err   = '0;
    o_wbm_stall = '1;
    for (int m = 0; m < numm; m++) begin
      if (w_own && GW'(m) == w_grant) begin
        o_wbm_stall[m]        = w_own_stall;
        o_wbm_ack[m]          = w_sack;
        o_wbm_err[m]          = w_serr || r_unm_pend || w_timeout;
        o_wbm_dat[m*32 +: 32] = w_tgt_dat;
      end
    end
  end

  assign o_grant   = w_grant;
  assign o_busy    = w_arb_valid;
  assign o_bus_err = r_unm_pend || w_timeout;

endmodule

// File: tb/tb_wb_interconnect_rr.sv
// Directed bench for wb_interconnect_rr: 2 masters, 5 slaves, MAX_OUTST=4,
// TIMEOUT=16. Inputs change just after the falling edge; outputs are
// checked 1 time unit later, well away from the rising edge.
module tb_wb_interconnect_rr;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    m_cyc, m_stb, m_we;
  logic [7:0]    m_sel;
  logic [63:0]   m_adr, m_wdat, m_rdat;
  logic [1:0]    m_ack, m_err, m_stall;
  logic [4:0]    s_cyc, s_stb, s_we;
  logic [19:0]   s_sel;
  logic [159:0]  s_adr, s_wdat, s_rdat;
  logic [4:0]    s_ack, s_err, s_stall;
  logic [0:0]    grant;
  logic          busy, bus_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_interconnect_rr #(
    .numm      (2),
    .nums      (5),
    .MAX_OUTST (4),
    .TIMEOUT   (16)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .i_wbm_cyc   (m_cyc),
    .i_wbm_stb   (m_stb),
    .i_wbm_we    (m_we),
    .i_wbm_sel   (m_sel),
    .i_wbm_adr   (m_adr),
    .i_wbm_dat   (m_wdat),
    .o_wbm_dat   (m_rdat),
    .o_wbm_ack   (m_ack),
    .o_wbm_err   (m_err),
    .o_wbm_stall (m_stall),
    .o_wbs_cyc   (s_cyc),
    .o_wbs_stb   (s_stb),
    .o_wbs_we    (s_we),
    .o_wbs_sel   (s_sel),
    .o_wbs_adr   (s_adr),
    .o_wbs_dat   (s_wdat),
    .i_wbs_dat   (s_rdat),
    .i_wbs_ack   (s_ack),
    .i_wbs_err   (s_err),
    .i_wbs_stall (s_stall),
    .o_grant     (grant),
    .o_busy      (busy),
    .o_bus_err   (bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    m_cyc = '0; m_stb = '0; m_we = '0; m_sel = 8'hFF; m_adr = '0; m_wdat = '0;
    s_rdat = '0; s_ack = '0; s_err = '0; s_stall = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_stall", m_stall, 2'b11);
    chk("rst_ackerr", {m_err, m_ack}, 0);
    chk("rst_slave", {s_cyc, s_stb}, 0);
    chk("rst_buserr", bus_err, 0);
    rst = 1'b0;

    // Arbitration: contention, release, alternation.
    m_cyc = 2'b11; #1;
    chk("arb_idle", busy, 0);
    tick();
    chk("arb_busy", busy, 1);
    chk("arb_grant0", grant, 0);
    chk("arb_nonown_stall", m_stall[1], 1);
    m_cyc = 2'b10; tick();
    chk("arb_release", busy, 0);
    tick();
    chk("arb_grant1", grant, 1);
    chk("arb_busy1", busy, 1);
    m_cyc = 2'b00; tick();
    m_cyc = 2'b11; tick();
    chk("arb_alt0", grant, 0);
    m_cyc = 2'b00; tick();

    // GPIO0 read.
    m_cyc = 2'b01; m_adr[31:0] = 32'h1000_0000; tick();
    chk("gp_grant", grant, 0);
    m_stb = 2'b01; #1;
    chk("gp_stb", s_stb, 5'b00010);
    chk("gp_adr", s_adr[63:32], 32'h1000_0000);
    chk("gp_stall", m_stall[0], 0);
    tick();
    m_stb = 2'b00; s_ack = 5'b00010; s_rdat[63:32] = 32'hA5; #1;
    chk("gp_ack", m_ack, 2'b01);
    chk("gp_dat", m_rdat[31:0], 32'hA5);
    tick();
    s_ack = '0; #1;
    chk("gp_ack_clr", m_ack, 0);
    m_cyc = 2'b00; tick();

    // Unmapped access.
    m_cyc = 2'b01; m_adr[31:0] = 32'h2000_0000; tick();
    m_stb = 2'b01; #1;
    chk("um_accept", m_stall[0], 0);
    chk("um_nostb", s_stb, 0);
    tick();
    m_stb = 2'b00; #1;
    chk("um_err", m_err, 2'b01);
    chk("um_buserr", bus_err, 1);
    chk("um_nostb2", s_stb, 0);
    tick();
    chk("um_clr", {bus_err, m_err}, 0);
    m_cyc = 2'b00; tick();

    // Pipelined RAM reads up to the outstanding limit.
    m_cyc = 2'b01; m_adr[31:0] = 32'h0000_0100; tick();
    m_stb = 2'b01;
    for (int i = 0; i < 4; i++) begin
      #1 chk("pl_accept", m_stall[0], 0);
      tick();
    end
    #1;
    chk("pl_full_stall", m_stall[0], 1);
    chk("pl_full_nostb", s_stb, 0);
    tick();
    s_ack = 5'b00001; #1;
    chk("pl_ack1", m_ack[0], 1);
    chk("pl_still_full", m_stall[0], 1);
    tick();
    s_ack = '0; #1;
    chk("pl_fifth", m_stall[0], 0);
    chk("pl_fifth_stb", s_stb, 5'b00001);
    tick();
    m_stb = 2'b00; s_ack = 5'b00001;
    for (int i = 0; i < 4; i++) begin
      #1 chk("pl_rest_ack", m_ack[0], 1);
      tick();
    end
    s_ack = '0; m_cyc = 2'b00; tick();
    chk("pl_idle", busy, 0);

    // Ordering: GPIO1 beat waits for the RAM beat.
    m_cyc = 2'b01; m_adr[31:0] = 32'h0000_0200; tick();
    m_stb = 2'b01; tick();
    m_adr[31:0] = 32'h1000_1000; #1;
    chk("or_stall", m_stall[0], 1);
    chk("or_nostb", s_stb, 0);
    chk("or_cyc_ram", s_cyc, 5'b00001);
    tick();
    s_ack = 5'b00001; #1;
    chk("or_ram_ack", m_ack[0], 1);
    chk("or_stall2", m_stall[0], 1);
    tick();
    s_ack = '0; #1;
    chk("or_fwd_stb", s_stb, 5'b00100);
    chk("or_fwd_cyc", s_cyc, 5'b00100);
    chk("or_fwd_stall", m_stall[0], 0);
    tick();
    m_stb = 2'b00; s_ack = 5'b00100; #1;
    chk("or_gp1_ack", m_ack[0], 1);
    tick();
    s_ack = '0; m_cyc = 2'b00; tick();

    // Watchdog: slave never answers.
    m_cyc = 2'b01; m_adr[31:0] = 32'h0000_0300; tick();
    m_stb = 2'b01; tick();
    m_stb = 2'b00;
    for (int k = 1; k < 16; k++) begin
      #1 chk("to_quiet", {bus_err, m_err[0]}, 0);
      tick();
    end
    #1;
    chk("to_err", m_err[0], 1);
    chk("to_buserr", bus_err, 1);
    chk("to_cyc_drop", s_cyc, 0);
    tick();
    s_ack = 5'b00001; #1;
    chk("to_late_ack", m_ack[0], 0);
    chk("to_err_clr", m_err[0], 0);
    chk("to_cyc_back", s_cyc, 5'b00001);
    tick();
    s_ack = '0; m_cyc = 2'b00; tick();

    // Asynchronous reset in the middle of a transaction.
    m_cyc = 2'b01; m_adr[31:0] = 32'h0000_0400; tick();
    m_stb = 2'b01; tick();
    m_stb = 2'b00; #1;
    chk("rm_busy_pre", busy, 1);
    #1 rst = 1'b1;
    #1;
    chk("rm_busy", busy, 0);
    chk("rm_slave", {s_cyc, s_stb}, 0);
    chk("rm_stall", m_stall, 2'b11);
    chk("rm_ackerr", {m_err, m_ack}, 0);
    m_cyc = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
